sys_ctrl: RTL

Command controller between the UART receive path and the system core. It parses byte-wise commands from the receiver, sequences register-file writes and reads and ALU operations, and queues results into the transmit FIFO. It owns the ALU clock-gate enable, so the ALU clock runs only while an ALU command is in flight.

---
 rtl/sys_ctrl_pkg.sv | 32 +++
 rtl/sys_ctrl_tx_sender.sv | 60 ++++++
 rtl/sys_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, FSM states and operand register map for the command controller.
package sys_ctrl_pkg;

  localparam logic [7:0] WR_CMD      = 8'hAA;
  localparam logic [7:0] RD_CMD      = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FUN  = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10
  } state_e;

  // The ALU clock runs for the whole ALU command, including its result transfer.
  function automatic logic gate_state(input state_e s, input logic alu_cmd);
    return (s inside {ALU_A, ALU_B, ALU_FUN, ALU_WAIT}) ||
           ((s inside {TX_LO, TX_HI}) && alu_cmd);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_sender.sv
// Pushes a 1- or 2-byte result (low byte first) into the TX FIFO under backpressure.
module sys_ctrl_tx_sender #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    two_bytes,
  input  logic [2*DATA_WIDTH-1:0] data,
  input  logic                    tx_fifo_full,
  output logic                    tx_wr_en,
  output logic [DATA_WIDTH-1:0]   tx_wr_data,
  output logic                    done
);

  logic                    busy;
  logic                    sel_hi;
  logic                    two_q;
  logic [2*DATA_WIDTH-1:0] data_q;

  // start is taken combinationally so a free FIFO sees the low byte one cycle after the result strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      sel_hi     <= 1'b0;
      two_q      <= 1'b0;
      data_q     <= '0;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= '0;
      done       <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      done     <= 1'b0;
      if (start) begin
        data_q <= data;
        two_q  <= two_bytes;
        if (!tx_fifo_full) begin
          tx_wr_en   <= 1'b1;
          tx_wr_data <= data[DATA_WIDTH-1:0];
          busy       <= two_bytes;
          sel_hi     <= two_bytes;
          done       <= !two_bytes;
        end else begin
          busy   <= 1'b1;
          sel_hi <= 1'b0;
        end
      end else if (busy && !tx_fifo_full) begin
        tx_wr_en   <= 1'b1;
        tx_wr_data <= sel_hi ? data_q[2*DATA_WIDTH-1:DATA_WIDTH] : data_q[DATA_WIDTH-1:0];
        if (sel_hi || !two_q) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          sel_hi <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Byte-wise command parser sequencing register-file and ALU accesses and queuing results to TX.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   reg_rd_data,
  input  logic                    reg_rd_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    tx_fifo_full,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_wr_en,
  output logic [DATA_WIDTH-1:0]   reg_wr_data,
  output logic                    reg_rd_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    alu_en,
  output logic                    clk_gate_en,
  output logic                    tx_wr_en,
  output logic [DATA_WIDTH-1:0]   tx_wr_data,
  output logic                    cmd_err
);

  state_e state, state_nx;
  logic   alu_cmd, alu_cmd_nx;
  logic   op_wr, op_rd, op_alu, op_nop, op_known;
  logic   tx_start, tx_two, tx_done;
  logic [2*DATA_WIDTH-1:0] tx_data;

  assign op_wr    = (rx_p_data == DATA_WIDTH'(WR_CMD));
  assign op_rd    = (rx_p_data == DATA_WIDTH'(RD_CMD));
  assign op_alu   = (rx_p_data == DATA_WIDTH'(ALU_OP_CMD));
  assign op_nop   = (rx_p_data == DATA_WIDTH'(ALU_NOP_CMD));
  assign op_known = op_wr | op_rd | op_alu | op_nop;

  assign tx_two   = (state == ALU_WAIT);
  assign tx_start = ((state == RD_WAIT) && reg_rd_vld) || ((state == ALU_WAIT) && alu_out_vld);
  assign tx_data  = tx_two ? alu_out : {{DATA_WIDTH{1'b0}}, reg_rd_data};

  always_comb begin
    state_nx   = state;
    alu_cmd_nx = alu_cmd;
    case (state)
      IDLE: if (rx_d_vld) begin
        alu_cmd_nx = op_alu | op_nop;
        if (op_wr)       state_nx = WR_ADDR;
        else if (op_rd)  state_nx = RD_ADDR;
        else if (op_alu) state_nx = ALU_A;
        else if (op_nop) state_nx = ALU_FUN;
      end
      WR_ADDR:  if (rx_d_vld) state_nx = WR_DATA;
      WR_DATA:  if (rx_d_vld) state_nx = IDLE;
      RD_ADDR:  if (rx_d_vld) state_nx = RD_WAIT;
      RD_WAIT:  if (reg_rd_vld) state_nx = TX_LO;
      ALU_A:    if (rx_d_vld) state_nx = ALU_B;
      ALU_B:    if (rx_d_vld) state_nx = ALU_FUN;
      ALU_FUN:  if (rx_d_vld) state_nx = ALU_WAIT;
      ALU_WAIT: if (alu_out_vld) state_nx = TX_LO;
      // The low-byte write strobe itself marks the hand-over to the high byte
      TX_LO: begin
        if (tx_done)                 state_nx = IDLE;
        else if (tx_wr_en && alu_cmd) state_nx = TX_HI;
      end
      TX_HI:    if (tx_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_cmd     <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      alu_cmd     <= alu_cmd_nx;
      clk_gate_en <= gate_state(state_nx, alu_cmd_nx);
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      alu_en      <= 1'b0;
      cmd_err     <= 1'b0;
      if (rx_d_vld) begin
        case (state)
          IDLE:    cmd_err <= !op_known;
          WR_ADDR: reg_addr <= rx_p_data[ADDR_WIDTH-1:0];
          WR_DATA: begin
            reg_wr_en   <= 1'b1;
            reg_wr_data <= rx_p_data;
          end
          RD_ADDR: begin
            reg_addr  <= rx_p_data[ADDR_WIDTH-1:0];
            reg_rd_en <= 1'b1;
          end
          ALU_A: begin
            reg_addr    <= ADDR_WIDTH'(OPA_ADDR);
            reg_wr_en   <= 1'b1;
            reg_wr_data <= rx_p_data;
          end
          ALU_B: begin
            reg_addr    <= ADDR_WIDTH'(OPB_ADDR);
            reg_wr_en   <= 1'b1;
            reg_wr_data <= rx_p_data;
          end
          ALU_FUN: begin
            alu_fun <= rx_p_data[FUN_WIDTH-1:0];
            alu_en  <= 1'b1;
          end
          default: cmd_err <= 1'b1;
        endcase
      end
    end
  end

  sys_ctrl_tx_sender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_sender (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (tx_start),
    .two_bytes    (tx_two),
    .data         (tx_data),
    .tx_fifo_full (tx_fifo_full),
    .tx_wr_en     (tx_wr_en),
    .tx_wr_data   (tx_wr_data),
    .done         (tx_done)
  );

endmodule
